hazard_unit_mc: RTL and testbench
=================================

// Module: hazard_unit_mc
// PURPOSE
//  Next-generation pipeline hazard unit for the 5-stage 16-bit core; sits in decode beside the register file.
//  Detects load-use hazards and holds the front end for LU_BUBBLES cycles (counter-driven, not purely combinational).
//  Adds whole-pipe freeze for multi-cycle data memory (mem_busy) and front-end flush on taken branch/jump.
// PARAMETERS
//  INSTR_W     16  instruction width
//  REG_W       3   register-specifier width
//  RS_LSB      8   LSB of Rs field in instruction
//  RT_LSB      5   LSB of Rt field in instruction
//  LD_DST_LSB  5   LSB of load destination field in ID/EX instruction
//  LU_BUBBLES  1   bubbles per load-use hazard (1..3; 2 when no MEM->EX forwarding)
//  CNT_W       16  width of stall statistics counter (STALL_STATS_EN only)
// PORTS
//  clk           in   1        clock, rising edge
//  rst_n         in   1        asynchronous reset, active low
//  ifid_instr    in   INSTR_W  instruction in IF/ID
//  idex_instr    in   INSTR_W  instruction in ID/EX
//  valid_rs      in   1        ID instruction reads Rs
//  valid_rt      in   1        ID instruction reads Rt
//  idex_mem_en   in   1        ID/EX instruction accesses memory
//  idex_mem_wr   in   1        ID/EX memory access is a store
//  mem_busy      in   1        data memory not ready this cycle
//  br_taken      in   1        EX resolved a taken branch/jump this cycle
//  pc_wr_en      out  1        1 = PC may update
//  ifid_wr_en    out  1        1 = IF/ID may update
//  ctrl_sel      out  1        1 = pass decoded controls, 0 = inject bubble into ID/EX
//  ifid_flush    out  1        squash IF/ID contents
//  idex_flush    out  1        squash ID/EX contents
//  pipe_hold     out  1        freeze ID/EX, EX/MEM, MEM/WB
//  stall_cycles  out  CNT_W    saturating stall-cycle count (STALL_STATS_EN only)
// BEHAVIOUR
//  - lu_hit = idex_mem_en & ~idex_mem_wr & ((valid_rs & dst==ifid.Rs) | (valid_rt & dst==ifid.Rt)).
//  - FSM {RUN, LU_STALL}; down-counter bub_cnt [2 bits]. rst_n low: RUN, bub_cnt=0, stall_cycles=0.
//  - Outputs while rst_n low: pc_wr_en=1, ifid_wr_en=1, ctrl_sel=1, flushes=0, pipe_hold=0.
//  - Priority per cycle: mem_busy > br_taken > load-use > run.
//  - mem_busy=1: pipe_hold=1, pc_wr_en=0, ifid_wr_en=0, ctrl_sel=1, flushes=0; state and bub_cnt frozen.
//  - br_taken=1 (mem_busy=0): ifid_flush=1, idex_flush=1, pc_wr_en=1, ifid_wr_en=1; next state RUN, bub_cnt=0
//    (pending load-use stall cancelled; its consumer is squashed).
//  - RUN & lu_hit: same cycle pc_wr_en=0, ifid_wr_en=0, ctrl_sel=0 (bubble #1).
//    LU_BUBBLES==1 -> stay RUN; else -> LU_STALL, bub_cnt=LU_BUBBLES-1.
//  - LU_STALL: stall outputs as above regardless of lu_hit; bub_cnt decrements; at bub_cnt==1 -> RUN next cycle.
//  - RUN & ~lu_hit: all enables 1, ctrl_sel=1, flushes 0, pipe_hold 0.
//  - Load immediately followed by store of same reg as data (Rt): stalls (no special store-data forwarding).
//  - Async reset mid-stall: returns to RUN immediately; no residual bubbles.
//  - All outputs combinational from state + inputs; no output latency beyond that.
// CONFIGURATION
//  - STALL_STATS_EN defined: stall_cycles increments each cycle pc_wr_en==0 (load-use or mem_busy),
//    saturates at all-ones, cleared only by reset.
//  - Not defined: stall_cycles port absent; no counter flops.
// STRUCTURE
//  - Package hazard_pkg: field-LSB constants, state encoding (RUN=1'b0, LU_STALL=1'b1), LU_BUBBLES range check.
//  - Sub-module hazard_match: combinational register-specifier compare producing lu_hit; FSM/counter stay in top.
// TESTING
//  - ld r2 in ID/EX (dst=2), ID reads Rs=2, valid_rs=1, LU_BUBBLES=1 -> exactly 1 cycle pc_wr_en=0, ctrl_sel=0.
//  - Same, LU_BUBBLES=2 -> 2 consecutive stall cycles, then RUN; PC advances on 3rd cycle.
//  - ld r3, ID reads Rt=3 with valid_rt=0 -> no stall; st (mem_wr=1) to r3 -> no stall.
//  - LU_BUBBLES=2 stall, mem_busy=1 for 3 cycles in LU_STALL -> pipe_hold=1 3 cycles, then 1 remaining bubble.
//  - lu_hit and br_taken same cycle -> ifid_flush=idex_flush=1, no bubble, state RUN next cycle.
//  - rst_n low in LU_STALL -> RUN immediately; STALL_STATS_EN: stall_cycles=0, counts 4 after 4 stall cycles.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hazard_pkg                                                      |
// | Brief    : Shared constants, FSM encoding and parameter range helper for   |
// |            the decode-stage hazard unit.                                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package hazard_pkg;

    // Default instruction geometry for the 16-bit core
    localparam int c_INSTR_W    = 16;
    localparam int c_REG_W      = 3;
    localparam int c_RS_LSB     = 8;
    localparam int c_RT_LSB     = 5;
    localparam int c_LD_DST_LSB = 5;

    // Default stall behaviour and statistics width
    localparam int c_LU_BUBBLES = 1;
    localparam int c_CNT_W      = 16;

    // Hazard FSM: RUN = normal flow, LU_STALL = extra load-use bubbles pending
    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } state_t;

    // The bubble counter is 2 bits wide, so only 1..3 bubbles are representable
    function automatic bit lu_bubbles_ok(input int n);
        return (n >= 1) && (n <= 3);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_match.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hazard_match                                                    |
// | Brief    : Combinational load-use detector. Compares the destination of a |
// |            load in ID/EX against the source registers read in ID.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
import hazard_pkg::*;

module hazard_match #(
    parameter int INSTR_W    = c_INSTR_W,
    parameter int REG_W      = c_REG_W,
    parameter int RS_LSB     = c_RS_LSB,
    parameter int RT_LSB     = c_RT_LSB,
    parameter int LD_DST_LSB = c_LD_DST_LSB
) (
    input  logic [INSTR_W-1:0] i_ifid_instr,
    input  logic [INSTR_W-1:0] i_idex_instr,
    input  logic               i_valid_rs,
    input  logic               i_valid_rt,
    input  logic               i_idex_mem_en,
    input  logic               i_idex_mem_wr,
    output logic               o_lu_hit
);

    logic [REG_W-1:0] w_dst;
    logic [REG_W-1:0] w_rs;
    logic [REG_W-1:0] w_rt;
    logic             w_is_load;
    logic             w_rs_hit;
    logic             w_rt_hit;

    assign w_dst = i_idex_instr[LD_DST_LSB +: REG_W];
    assign w_rs  = i_ifid_instr[RS_LSB +: REG_W];
    assign w_rt  = i_ifid_instr[RT_LSB +: REG_W];

    // Stores do not write the register file, so only loads can create the hazard
    assign w_is_load = i_idex_mem_en & ~i_idex_mem_wr;
    assign w_rs_hit  = i_valid_rs & (w_dst == w_rs);
    // Rt used as store data still stalls: there is no store-data forwarding path
    assign w_rt_hit  = i_valid_rt & (w_dst == w_rt);

    assign o_lu_hit  = w_is_load & (w_rs_hit | w_rt_hit);

    // Opcode and immediate bits are irrelevant to hazard detection
    logic w_unused_bits;
    assign w_unused_bits = &{1'b0, i_ifid_instr, i_idex_instr};

endmodule
`default_nettype wire

// File: rtl/hazard_unit_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hazard_unit_mc                                                  |
// | Brief    : Decode-stage hazard unit: counter-driven load-use stall,        |
// |            whole-pipe freeze on busy data memory, front-end flush on taken |
// |            branch/jump. Optional STALL_STATS_EN macro adds a saturating    |
// |            stall-cycle counter and the stall_cycles output port.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
import hazard_pkg::*;

module hazard_unit_mc #(
    parameter int INSTR_W    = c_INSTR_W,
    parameter int REG_W      = c_REG_W,
    parameter int RS_LSB     = c_RS_LSB,
    parameter int RT_LSB     = c_RT_LSB,
    parameter int LD_DST_LSB = c_LD_DST_LSB,
    parameter int LU_BUBBLES = c_LU_BUBBLES
`ifdef STALL_STATS_EN
    ,
    parameter int CNT_W      = c_CNT_W
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] ifid_instr,
    input  logic [INSTR_W-1:0] idex_instr,
    input  logic               valid_rs,
    input  logic               valid_rt,
    input  logic               idex_mem_en,
    input  logic               idex_mem_wr,
    input  logic               mem_busy,
    input  logic               br_taken,
    output logic               pc_wr_en,
    output logic               ifid_wr_en,
    output logic               ctrl_sel,
    output logic               ifid_flush,
    output logic               idex_flush,
    output logic               pipe_hold
`ifdef STALL_STATS_EN
    ,
    output logic [CNT_W-1:0]   stall_cycles
`endif
);

    // Reject bubble counts the 2-bit down-counter cannot express
    if (!lu_bubbles_ok(LU_BUBBLES)) begin : g_bad_lu_bubbles
        $error("hazard_unit_mc: LU_BUBBLES must be in 1..3");
    end

    state_t     r_state;
    logic [1:0] r_bub_cnt;
    logic       w_lu_hit;
    logic       w_stall;

    hazard_match #(
        .INSTR_W    (INSTR_W),
        .REG_W      (REG_W),
        .RS_LSB     (RS_LSB),
        .RT_LSB     (RT_LSB),
        .LD_DST_LSB (LD_DST_LSB)
    ) u_match (
        .i_ifid_instr  (ifid_instr),
        .i_idex_instr  (idex_instr),
        .i_valid_rs    (valid_rs),
        .i_valid_rt    (valid_rt),
        .i_idex_mem_en (idex_mem_en),
        .i_idex_mem_wr (idex_mem_wr),
        .o_lu_hit      (w_lu_hit)
    );

    // While bubbles remain the stall holds even if the hazard pattern has gone away
    assign w_stall = (r_state == LU_STALL) | w_lu_hit;

    // Output decode by priority: memory freeze, branch flush, load-use bubble, run
    always_comb begin
        pc_wr_en   = 1'b1;
        ifid_wr_en = 1'b1;
        ctrl_sel   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        pipe_hold  = 1'b0;
        if (rst_n) begin
            if (mem_busy) begin
                pipe_hold  = 1'b1;
                pc_wr_en   = 1'b0;
                ifid_wr_en = 1'b0;
            end else if (br_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (w_stall) begin
                pc_wr_en   = 1'b0;
                ifid_wr_en = 1'b0;
                ctrl_sel   = 1'b0;
            end
        end
    end

    // Load-use FSM; r_bub_cnt counts the bubbles still owed after the current one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RUN;
            r_bub_cnt <= 2'd0;
        end else if (mem_busy) begin
            r_state   <= r_state;
            r_bub_cnt <= r_bub_cnt;
        end else if (br_taken) begin
            // The stalled consumer is being squashed, so drop any owed bubbles
            r_state   <= RUN;
            r_bub_cnt <= 2'd0;
        end else if (r_state == LU_STALL) begin
            if (r_bub_cnt == 2'd1) begin
                r_state   <= RUN;
                r_bub_cnt <= 2'd0;
            end else begin
                r_bub_cnt <= r_bub_cnt - 2'd1;
            end
        end else if (w_lu_hit) begin
            if (LU_BUBBLES > 1) begin
                r_state   <= LU_STALL;
                r_bub_cnt <= 2'(LU_BUBBLES - 1);
            end
        end
    end

`ifdef STALL_STATS_EN
    logic [CNT_W-1:0] r_stall_cycles;

    // Count every cycle the PC is held, sticking at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (!pc_wr_en && (r_stall_cycles != {CNT_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_hazard_unit_mc                                               |
// | Brief    : Scoreboard bench for hazard_unit_mc with LU_BUBBLES = 1, 2, 3   |
// |            instances sharing one stimulus stream.                          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_hazard_unit_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ifid_instr;
    logic [15:0] idex_instr;
    logic        valid_rs;
    logic        valid_rt;
    logic        idex_mem_en;
    logic        idex_mem_wr;
    logic        mem_busy;
    logic        br_taken;

    logic [2:0]  pc_o;
    logic [2:0]  ifidwr_o;
    logic [2:0]  ctrl_o;
    logic [2:0]  iff_o;
    logic [2:0]  idf_o;
    logic [2:0]  hold_o;
`ifdef STALL_STATS_EN
    logic [15:0] st_o [3];
`endif

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        hazard_unit_mc #(.LU_BUBBLES(gi + 1)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .ifid_instr   (ifid_instr),
            .idex_instr   (idex_instr),
            .valid_rs     (valid_rs),
            .valid_rt     (valid_rt),
            .idex_mem_en  (idex_mem_en),
            .idex_mem_wr  (idex_mem_wr),
            .mem_busy     (mem_busy),
            .br_taken     (br_taken),
            .pc_wr_en     (pc_o[gi]),
            .ifid_wr_en   (ifidwr_o[gi]),
            .ctrl_sel     (ctrl_o[gi]),
            .ifid_flush   (iff_o[gi]),
            .idex_flush   (idf_o[gi]),
            .pipe_hold    (hold_o[gi])
`ifdef STALL_STATS_EN
            ,
            .stall_cycles (st_o[gi])
`endif
        );
    end

    // Expected outputs for one instance: {pc,ifid_wr,ctrl,ifid_fl,idex_fl,hold}, stats
    typedef struct packed {
        logic [5:0]  o;
        logic [15:0] st;
    } exp1_t;
    typedef exp1_t [2:0] exp3_t;

    exp3_t q[$];
    int    rem [3];
    int    stat [3];
    int    errors = 0;
    int    checks = 0;

    // Load-use rule evaluated on register numbers pulled out with plain arithmetic
    function automatic bit model_hit(input logic [15:0] ifid, input logic [15:0] idex,
                                     input logic vrs, input logic vrt,
                                     input logic men, input logic mwr);
        int dst;
        int rs;
        int rt;
        dst = (int'(idex) >> 5) % 8;
        rs  = (int'(ifid) >> 8) % 8;
        rt  = (int'(ifid) >> 5) % 8;
        return men && !mwr && ((vrs && dst == rs) || (vrt && dst == rt));
    endfunction

    function automatic logic [15:0] mk_ld(input int dst);
        return 16'(dst * 32);
    endfunction

    function automatic logic [15:0] mk_id(input int rs, input int rt);
        return 16'(rs * 256 + rt * 32);
    endfunction

    // Apply one cycle of stimulus and push what every instance should show
    task automatic step(input logic rstn, input logic [15:0] ifid, input logic [15:0] idex,
                        input logic vrs, input logic vrt, input logic men, input logic mwr,
                        input logic busy, input logic br);
        exp3_t e;
        bit    hit;
        logic  pc, iw, cs, fl, hold;
        @(posedge clk);
        #1;
        rst_n       = rstn;
        ifid_instr  = ifid;
        idex_instr  = idex;
        valid_rs    = vrs;
        valid_rt    = vrt;
        idex_mem_en = men;
        idex_mem_wr = mwr;
        mem_busy    = busy;
        br_taken    = br;
        hit = model_hit(ifid, idex, vrs, vrt, men, mwr);
        for (int k = 0; k < 3; k++) begin
            pc = 1'b1; iw = 1'b1; cs = 1'b1; fl = 1'b0; hold = 1'b0;
            if (!rstn) begin
                rem[k]  = 0;
                stat[k] = 0;
            end
            e[k].st = 16'(stat[k]);
            if (!rstn) begin
                // defaults already set
            end else if (busy) begin
                pc = 1'b0; iw = 1'b0; hold = 1'b1;
                if (stat[k] < 65535) stat[k]++;
            end else if (br) begin
                fl = 1'b1;
                rem[k] = 0;
            end else if (rem[k] > 0 || hit) begin
                pc = 1'b0; iw = 1'b0; cs = 1'b0;
                rem[k] = (rem[k] > 0) ? rem[k] - 1 : k;
                if (stat[k] < 65535) stat[k]++;
            end
            e[k].o = {pc, iw, cs, fl, fl, hold};
        end
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: pop one expectation per cycle with stimulus pending and compare
    initial begin
        exp3_t       e;
        logic [5:0]  act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int k = 0; k < 3; k++) begin
                    act = {pc_o[k], ifidwr_o[k], ctrl_o[k], iff_o[k], idf_o[k], hold_o[k]};
                    checks++;
                    if (act !== e[k].o) begin
                        errors++;
                        $display("FAIL outs_lub%0d t=%0t actual=%b required=%b (pc,ifid_wr,ctrl,ifid_fl,idex_fl,hold)",
                                 k + 1, $time, act, e[k].o);
                    end
`ifdef STALL_STATS_EN
                    checks++;
                    if (st_o[k] !== e[k].st) begin
                        errors++;
                        $display("FAIL stall_cycles_lub%0d t=%0t actual=%0d required=%0d",
                                 k + 1, $time, st_o[k], e[k].st);
                    end
`endif
                end
            end
        end
    end

    initial begin
        logic [15:0] ifid;
        logic [15:0] idex;
        rst_n = 1'b0; ifid_instr = '0; idex_instr = '0; valid_rs = 1'b0; valid_rt = 1'b0;
        idex_mem_en = 1'b0; idex_mem_wr = 1'b0; mem_busy = 1'b0; br_taken = 1'b0;

        // Reset state, with a would-be hazard present that must be ignored
        step(1'b0, mk_id(2, 0), mk_ld(2), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        // ld r2 / consumer reads Rs=2
        step(1'b1, mk_id(2, 0), mk_ld(2), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);
        // Rt match with valid_rt=0, then a store to r3: neither stalls
        step(1'b1, mk_id(0, 3), mk_ld(3), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, mk_id(0, 3), mk_ld(3), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);
        // Load followed by store of the same register as data (Rt) stalls
        step(1'b1, mk_id(1, 3), mk_ld(3), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);
        // Hazard, then memory busy for 3 cycles during the stall
        step(1'b1, mk_id(2, 0), mk_ld(2), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        // Hazard and taken branch in the same cycle
        step(1'b1, mk_id(5, 0), mk_ld(5), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(2);
        // Branch arriving while extra bubbles are still owed
        step(1'b1, mk_id(4, 0), mk_ld(4), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
        // Reset asserted mid-stall
        step(1'b1, mk_id(6, 0), mk_ld(6), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);
        // Four stall cycles from a clean count
        for (int i = 0; i < 4; i++) step(1'b1, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Randomized traffic with small register numbers so hazards are frequent
        for (int i = 0; i < 3000; i++) begin
            ifid = 16'($urandom);
            idex = 16'($urandom);
            ifid[10:8] = 3'($urandom_range(0, 3));
            ifid[7:5]  = 3'($urandom_range(0, 3));
            idex[7:5]  = 3'($urandom_range(0, 3));
            step($urandom_range(0, 99) >= 2, ifid, idex,
                 1'($urandom), 1'($urandom),
                 $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10);
        end

        // Drain: every expectation must have been consumed by the monitor
        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d pending required=0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
